// File: rtl/fifo_arb_pkg.sv
// Shared types and index helpers for the FIFO write-port arbiter.
// The owner index width is derived per module as ID_W = $clog2(NUM_REQ).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Requester index 'offs' positions after 'base', wrapping modulo n.
  function automatic int unsigned wrap_idx(int unsigned base, int unsigned offs, int unsigned n);
    return (base + offs) % n;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_chk.sv
// Run-time invariants of the FIFO write-port arbiter, kept apart from the datapath.
module fifo_wr_arbiter_chk #(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input logic               clk,
  input logic               rst,
  input logic [NUM_REQ-1:0] req_valid,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               fifo_full,
  input logic               fifo_wr_en,
  input logic               grant_active,
  input logic [CNT_W-1:0]   burst_cnt
);

  a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
    fifo_wr_en |-> !fifo_full);

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  a_write_is_handshake : assert property (@(posedge clk) disable iff (rst)
    fifo_wr_en == (|(req_ready & req_valid)));

  a_no_ready_without_grant : assert property (@(posedge clk) disable iff (rst)
    !grant_active |-> (req_ready == {NUM_REQ{1'b0}}));

  a_burst_bounded : assert property (@(posedge clk) disable iff (rst)
    burst_cnt <= CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i scanning ptr_i+1, ptr_i+2, ...
// with wrap-around; ptr_i itself is the last candidate examined.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [ID_W-1:0] cand_s;

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = {ID_W{1'b0}};
    cand_s  = {ID_W{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s  = ID_W'(wrap_idx(32'(ptr_i), k, NUM_REQ));
      found_o = found_o | req_i[cand_s];
      idx_o   = req_i[cand_s] ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO write port among NUM_REQ producers.
// Grant state is registered; the write path is combinational from that state and the inputs.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_active,
  output logic [ID_W-1:0]               grant_id
);

  localparam int                CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   PTR_RST    = ID_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic               gnt_s;
  logic               owner_valid_s;
  logic [NUM_REQ-1:0] owner_mask_s;
  logic               wr_s;
  logic               burst_end_s;
  logic               release_s;
  logic [NUM_REQ-1:0] pick_req_s;
  logic [ID_W-1:0]    pick_ptr_s;
  logic               pick_found_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic [DATA_WIDTH-1:0] data_sel_s;

  assign gnt_s         = (state_q == GRANT);
  assign owner_valid_s = req_valid[grant_id_q];
  assign owner_mask_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q;
  assign wr_s          = gnt_s & owner_valid_s & ~fifo_full;
  assign burst_end_s   = wr_s & (burst_cnt_q == BURST_LAST);
  assign release_s     = gnt_s & (~owner_valid_s | burst_end_s);

  // On release the outgoing owner is masked so it cannot win its own hand-over.
  assign pick_req_s = gnt_s ? (req_valid & ~owner_mask_s) : req_valid;
  assign pick_ptr_s = gnt_s ? grant_id_q : rr_ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (pick_req_s),
    .ptr_i   (pick_ptr_s),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Next-state: grant hand-over, burst counting and pointer update.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d     = GRANT;
          grant_id_d  = pick_idx_s;
          burst_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          rr_ptr_d    = grant_id_q;
          burst_cnt_d = {CNT_W{1'b0}};
          if (pick_found_s) begin
            grant_id_d = pick_idx_s;
          end else begin
            state_d = IDLE;
          end
        end else if (wr_s) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_id_d  = {ID_W{1'b0}};
        burst_cnt_d = {CNT_W{1'b0}};
        rr_ptr_d    = PTR_RST;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= {ID_W{1'b0}};
      burst_cnt_q <= {CNT_W{1'b0}};
      rr_ptr_q    <= PTR_RST;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Owner payload select; forced to zero whenever no write is issued.
  always_comb begin
    data_sel_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      data_sel_s = (grant_id_q == ID_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : data_sel_s;
    end
  end

  assign fifo_wr_en   = wr_s;
  assign fifo_data_in = wr_s ? data_sel_s : {DATA_WIDTH{1'b0}};
  assign req_ready    = (gnt_s & ~fifo_full) ? owner_mask_s : {NUM_REQ{1'b0}};
  assign grant_active = gnt_s;
  assign grant_id     = grant_id_q;

  fifo_wr_arbiter_chk #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .grant_active (grant_active),
    .burst_cnt    (burst_cnt_q)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers are payload queues, expected writes
// are queued in grant order and compared whenever the arbiter writes the FIFO.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_data_in;
  logic               grant_active;
  logic [1:0]         grant_id;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] prod_q[NR][$];
  int         wr_cyc[$];
  int         cyc;
  int         n_checks;
  int         n_fail;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mk(input int id, input int k);
    return 8'(id * 64 + k);
  endfunction

  task automatic load(input int id, input int k0, input int n);
    for (int j = 0; j < n; j++) prod_q[id].push_back(mk(id, k0 + j));
  endtask

  task automatic expect_beats(input int id, input int k0, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back({2'(id), mk(id, k0 + j)});
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = (prod_q[i].size() > 0);
      req_data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : 8'h00;
    end
  endtask

  // One clock: sample and score at negedge, consume accepted payloads, re-drive after posedge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (!rst) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("wr_is_handshake", 32'(fifo_wr_en), 32'(|(req_ready & req_valid)));
    end
    if (fifo_full) check("wr_while_full", 32'(fifo_wr_en), 32'd0);
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(fifo_wr_en), 32'd0);
      end else begin
        b = exp_q.pop_front();
        check("wr_id", 32'(grant_id), 32'(b.id));
        check("wr_data", 32'(fifo_data_in), 32'(b.d));
        wr_cyc.push_back(cyc);
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) void'(prod_q[i].pop_front());
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fifo_full = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    wr_cyc.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;

    // 1: reset with every requester valid
    for (int i = 0; i < NR; i++) load(i, 0, 1);
    drive();
    tick();
    #1;
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_gnt", 32'(grant_active), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    tick();
    check("rst_wr_en2", 32'(fifo_wr_en), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) expect_beats(i, 0, 1);
    drain("t1", 40);

    // 2: sole requester 0, six beats spanning a forced rotation
    do_reset();
    load(0, 0, 6);
    expect_beats(0, 0, 6);
    drive();
    drain("t2", 40);
    check("t2_count", 32'(wr_cyc.size()), 32'd6);

    // 3: all requesters busy, bursts of MB back to back in order 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 0, 8);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) expect_beats(i, r * 4, 4);
    drive();
    drain("t3", 80);
    if (wr_cyc.size() == 32) check("t3_back_to_back", 32'(wr_cyc[31] - wr_cyc[0]), 32'd31);
    else check("t3_count", 32'(wr_cyc.size()), 32'd32);

    // 4: owner 2 stalled by full after two writes; burst count must survive the stall
    do_reset();
    load(2, 0, 6);
    load(3, 0, 2);
    expect_beats(2, 0, 4);
    expect_beats(3, 0, 2);
    expect_beats(2, 4, 2);
    drive();
    repeat (3) tick();
    check("t4_pre_writes", 32'(wr_cyc.size()), 32'd2);
    fifo_full = 1'b1;
    repeat (3) begin
      #1;
      check("t4_full_no_wr", 32'(fifo_wr_en), 32'd0);
      check("t4_full_ready", 32'(req_ready), 32'd0);
      check("t4_full_gnt", 32'(grant_active), 32'd1);
      check("t4_full_gid", 32'(grant_id), 32'd2);
      tick();
    end
    fifo_full = 1'b0;
    drain("t4", 40);

    // 5: owner 1 drops valid after two writes; grant moves to waiting requester 3
    do_reset();
    load(1, 0, 2);
    load(3, 0, 3);
    expect_beats(1, 0, 2);
    expect_beats(3, 0, 3);
    drive();
    drain("t5", 40);
    if (wr_cyc.size() == 5) check("t5_handover_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
    else check("t5_count", 32'(wr_cyc.size()), 32'd5);

    // 6: reset mid-burst of owner 3, then restart favours index 0
    do_reset();
    load(3, 0, 6);
    expect_beats(3, 0, 2);
    drive();
    repeat (3) tick();
    check("t6_pre_writes", 32'(wr_cyc.size()), 32'd2);
    rst = 1'b1;
    load(0, 0, 2);
    drive();
    #1;
    check("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    check("t6_rst_gnt", 32'(grant_active), 32'd0);
    check("t6_rst_gid", 32'(grant_id), 32'd0);
    tick();
    check("t6_rst_wr_en2", 32'(fifo_wr_en), 32'd0);
    rst = 1'b0;
    expect_beats(0, 0, 2);
    expect_beats(3, 2, 4);
    drain("t6", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
